cu_prefetch_command_issue_control: RTL and testbench
====================================================

Name: cu_prefetch_command_issue_control

Overview:
Sits directly downstream of the prefetch stream engine command generator, inside the same compute unit. Accepts its per-cycle CommandBufferLine stream into a local FIFO and reports FIFO occupancy back as a BufferStatus, which the generator uses as backpressure. Arbitrates for the shared AFU command port with a request/grant handshake. Enforces a cap on in-flight reads by returning credits on matching responses.

Parameters:
FIFO_DEPTH, 32, command FIFO entries; power of two, >= 8
ALFULL_MARGIN, 4, free entries left when alfull asserts; must exceed upstream pipeline depth (3)
MAX_OUTSTANDING, 16, maximum issued-but-unresponded commands
CU_PREFETCH_CONTROL_ID, PREFETCH_READ_CONTROL_ID, cu_id whose responses return credits

Ports:
clock  in  1  clock; all logic on posedge
rstn  in  1  asynchronous active-low reset
enabled_in  in  1  block enable; registered once internally
prefetch_command_in  in  CommandBufferLine  commands from the stream engine; push when .valid
prefetch_response_in  in  ResponseBufferLine  response stream; credit return
command_arbiter_grant  in  1  arbiter grant, valid only while request high
prefetch_command_buffer_status  out  BufferStatus  registered FIFO status; fields valid/empty/alfull/full used
command_arbiter_request  out  1  registered request to the AFU command arbiter
prefetch_command_out  out  CommandBufferLine  registered issued command; .valid one-cycle pulse
outstanding_count  out  $clog2(MAX_OUTSTANDING+1)  current in-flight commands
issued_count  out  32  total commands issued since reset; wraps at 2^32
issue_error  out  1  sticky: FIFO overflow push or credit underflow

Behaviour:
- Reset values:
  - all outputs 0, except status.empty=1
  - FSM in DISABLED; FIFO pointers and all counters 0
- Enable:
  - enabled = enabled_in delayed by 1 cycle
  - pushes are accepted only while enabled
- FIFO push: prefetch_command_in.valid && enabled.
  - If full, the command is dropped and issue_error sets.
  - Push and pop in the same cycle are both performed; count is unchanged.
- Status, registered from next-state count:
  - empty = (count == 0)
  - full = (count == FIFO_DEPTH)
  - alfull = (count >= FIFO_DEPTH - ALFULL_MARGIN)
  - valid = enabled
- FSM states and transitions:
  - DISABLED → IDLE when enabled.
  - IDLE → REQUEST when all hold: FIFO non-empty, outstanding_count < MAX_OUTSTANDING, enabled.
  - REQUEST: command_arbiter_request = 1.
    - On grant: pop the FIFO head and go to ISSUE.
    - If enabled drops before grant: request deasserts next cycle, go to DISABLED, FIFO contents retained.
  - ISSUE:
    - prefetch_command_out takes the popped entry with valid=1; cmd.cu_id is forced to CU_PREFETCH_CONTROL_ID.
    - outstanding_count += 1; issued_count += 1.
    - Next state is REQUEST if the IDLE→REQUEST conditions still hold (evaluated after this cycle's pop and credit), else IDLE.
    - Result: at most one issue per 2 cycles.
- Latency:
  - grant at cycle N → prefetch_command_out.valid at N+1.
  - push at N → earliest request at N+2.
- Credits:
  - A credit returns when prefetch_response_in.valid && cmd.cu_id == CU_PREFETCH_CONTROL_ID; outstanding_count -= 1.
  - Issue and credit in the same cycle: count unchanged.
  - Credit at count 0: count stays 0 and issue_error sets.
  - Responses are honoured even when disabled.
- Grant without request is ignored. Request never asserts when outstanding_count == MAX_OUTSTANDING.
- prefetch_command_out is 0 in every cycle that is not ISSUE.
- Reset asserted mid-operation: all state clears immediately; FIFO contents are discarded; any in-flight credits are forgotten.

Decomposition:
- CU_PKG:
  - issue FSM enum (DISABLED, IDLE, REQUEST, ISSUE)
  - default parameter constants
- Existing types: CommandBufferLine, ResponseBufferLine, BufferStatus are reused unchanged.
- One sub-module: cu_prefetch_command_fifo, a parameterised synchronous FIFO with count output; the issue FSM and credit counter live in the top module.

Test Plan:
- Reset, then enable: push 1 command (address 0x1000); grant 1 cycle after request → out.valid one cycle with address 0x1000, cu_id=PREFETCH_READ_CONTROL_ID; outstanding=1, issued=1.
- Push 28 commands, no grant: alfull asserts on the registered status once count=28; push 5 more → full at 32, 33rd push dropped, issue_error=1, count stays 32.
- Grant held high, 20 queued, no responses → exactly 16 issues, then request stays 0; one matching response → outstanding 15, one more issue follows.
- Response with a different cu_id → no credit change; matching response in the same cycle as an issue → outstanding unchanged.
- Drop enabled_in while in REQUEST → request falls within 2 cycles, FIFO count preserved; re-enable → pending commands issue in original order.
- Assert rstn=0 with 10 queued and 5 outstanding → all outputs 0, status.empty=1; after release, no spurious request or output.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared types and defaults for the compute-unit prefetch command issue path.
//   CommandBufferLine  : command from the stream engine / to the AFU port
//   ResponseBufferLine : response stream entry; cmd.cu_id routes credits
//   BufferStatus       : FIFO occupancy report used as upstream backpressure
//   issue_state_e      : issue FSM states
package cu_pkg;

   localparam int CU_ID_W = 8;

   localparam int                 DEF_FIFO_DEPTH           = 32;
   localparam int                 DEF_ALFULL_MARGIN        = 4;
   localparam int                 DEF_MAX_OUTSTANDING      = 16;
   localparam logic [CU_ID_W-1:0] PREFETCH_READ_CONTROL_ID = 8'h0A;

   typedef struct packed {
      logic [CU_ID_W-1:0] cu_id;
      logic [7:0]         tag;
   } CommandMeta;

   typedef struct packed {
      logic        valid;
      logic [31:0] address;
      logic [7:0]  size;
      CommandMeta  cmd;
   } CommandBufferLine;

   typedef struct packed {
      logic       valid;
      CommandMeta cmd;
   } ResponseBufferLine;

   typedef struct packed {
      logic valid;
      logic empty;
      logic alfull;
      logic full;
   } BufferStatus;

   typedef enum logic [1:0] {
      DISABLED = 2'd0,
      IDLE     = 2'd1,
      REQUEST  = 2'd2,
      ISSUE    = 2'd3
   } issue_state_e;

endpackage

// File: rtl/cu_prefetch_command_fifo.sv
// Synchronous show-ahead FIFO with occupancy count.
//   push_i/wdata_i : write (ignored when full)
//   pop_i          : advance head (ignored when empty)
//   rdata_o        : current head entry
//   count_o        : current occupancy
//   count_nxt_o    : occupancy after this cycle's push/pop
module cu_prefetch_command_fifo #(
   parameter int DEPTH = 32,
   parameter int W     = 8
) (
   input  logic                         clock,
   input  logic                         rstn,
   input  logic                         push_i,
   input  logic                         pop_i,
   input  logic [W-1:0]                 wdata_i,
   output logic [W-1:0]                 rdata_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_nxt_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wptr_q, rptr_q;
   logic [CW-1:0] count_q;
   logic          push_ok, pop_ok;

   assign push_ok     = push_i && (count_q != CW'(DEPTH));
   assign pop_ok      = pop_i && (count_q != '0);
   assign count_nxt_o = count_q + CW'(push_ok) - CW'(pop_ok);
   assign count_o     = count_q;
   assign rdata_o     = mem_q[rptr_q];

   // DEPTH is a power of two, so pointers wrap naturally.
   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (push_ok) wptr_q <= wptr_q + AW'(1);
         if (pop_ok)  rptr_q <= rptr_q + AW'(1);
         count_q <= count_nxt_o;
      end
   end

   always_ff @(posedge clock) begin
      if (push_ok) mem_q[wptr_q] <= wdata_i;
   end

endmodule

// File: rtl/cu_prefetch_command_issue_control.sv
// Prefetch command issue control: buffers stream-engine commands, reports
// FIFO status as backpressure, arbitrates for the AFU command port and caps
// in-flight reads with a credit counter.
//   enabled_in                      : block enable (registered once)
//   prefetch_command_in             : commands to queue
//   prefetch_response_in            : responses; matching cu_id returns a credit
//   command_arbiter_grant           : arbiter grant
//   prefetch_command_buffer_status  : registered FIFO status
//   command_arbiter_request         : registered arbiter request
//   prefetch_command_out            : issued command, valid for one cycle
//   outstanding_count/issued_count  : in-flight and lifetime issue counters
//   issue_error                     : sticky overflow / credit underflow
module cu_prefetch_command_issue_control
   import cu_pkg::*;
#(
   parameter int                 FIFO_DEPTH             = DEF_FIFO_DEPTH,
   parameter int                 ALFULL_MARGIN          = DEF_ALFULL_MARGIN,
   parameter int                 MAX_OUTSTANDING        = DEF_MAX_OUTSTANDING,
   parameter logic [CU_ID_W-1:0] CU_PREFETCH_CONTROL_ID = PREFETCH_READ_CONTROL_ID
) (
   input  logic                                 clock,
   input  logic                                 rstn,
   input  logic                                 enabled_in,
   input  CommandBufferLine                     prefetch_command_in,
   input  ResponseBufferLine                    prefetch_response_in,
   input  logic                                 command_arbiter_grant,
   output BufferStatus                          prefetch_command_buffer_status,
   output logic                                 command_arbiter_request,
   output CommandBufferLine                     prefetch_command_out,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_count,
   output logic [31:0]                          issued_count,
   output logic                                 issue_error
);
   localparam int CW = $clog2(FIFO_DEPTH+1);
   localparam int OW = $clog2(MAX_OUTSTANDING+1);
   localparam logic [CW-1:0] FULL_TH  = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] ALF_TH   = CW'(FIFO_DEPTH - ALFULL_MARGIN);
   localparam logic [OW-1:0] OUT_MAX  = OW'(MAX_OUTSTANDING);

   issue_state_e     state_q;
   logic             enabled_q, request_q, err_q;
   CommandBufferLine cmd_out_q, head, issue_cmd;
   BufferStatus      status_q;
   logic [OW-1:0]    out_q, out_d;
   logic [31:0]      issued_q;
   logic [CW-1:0]    fifo_cnt, fifo_cnt_nxt;
   logic             push, pop, overflow, credit, issue_inc, underflow, can_req;
   logic [7:0]       unused_resp_tag;

   assign unused_resp_tag = prefetch_response_in.cmd.tag;

   assign push      = prefetch_command_in.valid && enabled_q;
   assign overflow  = push && (fifo_cnt == FULL_TH);
   assign pop       = (state_q == REQUEST) && command_arbiter_grant;
   assign credit    = prefetch_response_in.valid &&
                      (prefetch_response_in.cmd.cu_id == CU_PREFETCH_CONTROL_ID);
   assign issue_inc = (state_q == ISSUE);

   cu_prefetch_command_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     ($bits(CommandBufferLine))
   ) u_fifo (
      .clock       (clock),
      .rstn        (rstn),
      .push_i      (push),
      .pop_i       (pop),
      .wdata_i     (prefetch_command_in),
      .rdata_o     (head),
      .count_o     (fifo_cnt),
      .count_nxt_o (fifo_cnt_nxt)
   );

   // Issue and credit in the same cycle cancel; a credit with nothing in
   // flight is an error and leaves the count at zero.
   always_comb begin
      out_d     = out_q;
      underflow = 1'b0;
      if (issue_inc && !credit) begin
         out_d = out_q + OW'(1);
      end else if (!issue_inc && credit) begin
         if (out_q == '0) underflow = 1'b1;
         else             out_d     = out_q - OW'(1);
      end
   end

   // Uses the post-credit count so a freshly returned credit can re-arm the
   // request immediately; FIFO count is the registered one, giving push->request
   // a two-cycle latency.
   assign can_req = (fifo_cnt != '0) && (out_d < OUT_MAX) && enabled_q;

   always_comb begin
      issue_cmd           = head;
      issue_cmd.valid     = 1'b1;
      issue_cmd.cmd.cu_id = CU_PREFETCH_CONTROL_ID;
   end

   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
         state_q   <= DISABLED;
         request_q <= 1'b0;
         cmd_out_q <= '0;
      end else begin
         request_q <= 1'b0;
         cmd_out_q <= '0;
         case (state_q)
            DISABLED: if (enabled_q) state_q <= IDLE;
            IDLE: begin
               if (!enabled_q) begin
                  state_q <= DISABLED;
               end else if (can_req) begin
                  state_q   <= REQUEST;
                  request_q <= 1'b1;
               end
            end
            REQUEST: begin
               if (command_arbiter_grant) begin
                  state_q   <= ISSUE;
                  cmd_out_q <= issue_cmd;
               end else if (!enabled_q) begin
                  state_q <= DISABLED;
               end else begin
                  request_q <= 1'b1;
               end
            end
            ISSUE: begin
               if (can_req) begin
                  state_q   <= REQUEST;
                  request_q <= 1'b1;
               end else begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= DISABLED;
         endcase
      end
   end

   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
         enabled_q <= 1'b0;
         out_q     <= '0;
         issued_q  <= '0;
         err_q     <= 1'b0;
         status_q  <= '{valid: 1'b0, empty: 1'b1, alfull: 1'b0, full: 1'b0};
      end else begin
         enabled_q       <= enabled_in;
         out_q           <= out_d;
         issued_q        <= issued_q + 32'(issue_inc);
         if (overflow || underflow) err_q <= 1'b1;
         status_q.valid  <= enabled_in;
         status_q.empty  <= (fifo_cnt_nxt == '0);
         status_q.alfull <= (fifo_cnt_nxt >= ALF_TH);
         status_q.full   <= (fifo_cnt_nxt == FULL_TH);
      end
   end

   assign prefetch_command_buffer_status = status_q;
   assign command_arbiter_request        = request_q;
   assign prefetch_command_out           = cmd_out_q;
   assign outstanding_count              = out_q;
   assign issued_count                   = issued_q;
   assign issue_error                    = err_q;

endmodule

// File: tb/tb_cu_prefetch_command_issue_control.sv
module tb_cu_prefetch_command_issue_control;
   import cu_pkg::*;

   localparam logic [7:0] ID = PREFETCH_READ_CONTROL_ID;

   logic              clock = 1'b0;
   logic              rstn;
   logic              enabled_in;
   CommandBufferLine  cmd_in;
   ResponseBufferLine resp_in;
   logic              grant;
   BufferStatus       status;
   logic              request;
   CommandBufferLine  cmd_out;
   logic [4:0]        outstanding;
   logic [31:0]       issued;
   logic              err;

   int n_checks = 0;
   int n_pass   = 0;
   int issue_seen = 0;
   CommandBufferLine sb[$];

   always #5 clock = ~clock;

   cu_prefetch_command_issue_control dut (
      .clock                          (clock),
      .rstn                           (rstn),
      .enabled_in                     (enabled_in),
      .prefetch_command_in            (cmd_in),
      .prefetch_response_in           (resp_in),
      .command_arbiter_grant          (grant),
      .prefetch_command_buffer_status (status),
      .command_arbiter_request        (request),
      .prefetch_command_out           (cmd_out),
      .outstanding_count              (outstanding),
      .issued_count                   (issued),
      .issue_error                    (err)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic push_cmd(input logic [31:0] a, input bit accept);
      CommandBufferLine c;
      c             = '0;
      c.valid       = 1'b1;
      c.address     = a;
      c.size        = a[7:0] ^ 8'h5A;
      c.cmd.tag     = a[15:8] ^ a[7:0];
      c.cmd.cu_id   = 8'hEE;
      cmd_in        = c;
      if (accept) sb.push_back(c);
      step();
      cmd_in = '0;
   endtask

   task automatic resp(input logic [7:0] id);
      resp_in           = '0;
      resp_in.valid     = 1'b1;
      resp_in.cmd.cu_id = id;
      resp_in.cmd.tag   = 8'h33;
      step();
      resp_in = '0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_status"}, 64'(status), 64'(4'b0100));
      chk({tag, "_req"}, 64'(request), 64'd0);
      chk({tag, "_out"}, 64'(cmd_out), 64'd0);
      chk({tag, "_outst"}, 64'(outstanding), 64'd0);
      chk({tag, "_issued"}, 64'(issued), 64'd0);
      chk({tag, "_err"}, 64'(err), 64'd0);
   endtask

   // Scoreboard: every issued command must match the oldest accepted push.
   always @(negedge clock) begin
      if (rstn && cmd_out.valid) begin
         issue_seen++;
         if (sb.size() == 0) begin
            chk("sb_underrun", 64'd1, 64'd0);
         end else begin
            CommandBufferLine e;
            e = sb.pop_front();
            chk("out_payload", 64'({cmd_out.address, cmd_out.size, cmd_out.cmd.tag}),
                64'({e.address, e.size, e.cmd.tag}));
            chk("out_cu_id", 64'(cmd_out.cmd.cu_id), 64'(ID));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   typedef struct {
      int   n;
      logic alfull;
      logic full;
      logic err;
   } fill_vec_t;

   initial begin
      fill_vec_t tbl[5];
      int tot, base, spur;
      tbl[0] = '{27, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{1,  1'b1, 1'b0, 1'b0};
      tbl[2] = '{3,  1'b1, 1'b0, 1'b0};
      tbl[3] = '{1,  1'b1, 1'b1, 1'b0};
      tbl[4] = '{1,  1'b1, 1'b1, 1'b1};

      rstn = 1'b0; enabled_in = 1'b0; grant = 1'b0; cmd_in = '0; resp_in = '0;
      step(); step();
      chk_reset_outputs("rst0");
      rstn = 1'b1;
      enabled_in = 1'b1;
      step(); step(); step();
      chk("status_valid", 64'(status.valid), 64'd1);

      // Single command: latency and credit bookkeeping.
      push_cmd(32'h1000, 1'b1);
      chk("req_n1", 64'(request), 64'd0);
      step();
      chk("req_n2", 64'(request), 64'd1);
      step();
      grant = 1'b1;
      step();
      grant = 1'b0;
      chk("first_valid", 64'(cmd_out.valid), 64'd1);
      chk("first_addr", 64'(cmd_out.address), 64'h1000);
      step();
      chk("first_outst", 64'(outstanding), 64'd1);
      chk("first_issued", 64'(issued), 64'd1);
      chk("first_valid_clr", 64'(cmd_out.valid), 64'd0);
      chk("first_req_clr", 64'(request), 64'd0);

      // Fill to full without grant, then overflow.
      tot = 0;
      for (int v = 0; v < 5; v++) begin
         for (int k = 0; k < tbl[v].n; k++) begin
            push_cmd(32'h2000 + 32'(tot), tot < 32);
            tot++;
         end
         chk($sformatf("fill%0d_alfull", v), 64'(status.alfull), 64'(tbl[v].alfull));
         chk($sformatf("fill%0d_full", v), 64'(status.full), 64'(tbl[v].full));
         chk($sformatf("fill%0d_err", v), 64'(err), 64'(tbl[v].err));
      end
      chk("fill_empty", 64'(status.empty), 64'd0);

      // Reset with a full FIFO.
      rstn = 1'b0;
      #1;
      chk_reset_outputs("rst1");
      sb.delete();
      step();
      rstn = 1'b1;
      step(); step(); step();

      // Grant held high: outstanding cap stops issue at 16.
      base  = issue_seen;
      grant = 1'b1;
      for (int k = 0; k < 20; k++) push_cmd(32'h3000 + 32'(k * 16), 1'b1);
      for (int k = 0; k < 60; k++) step();
      chk("cap_issues", 64'(issue_seen - base), 64'd16);
      chk("cap_outst", 64'(outstanding), 64'd16);
      chk("cap_req", 64'(request), 64'd0);
      resp(ID);
      chk("credit_outst", 64'(outstanding), 64'd15);
      for (int k = 0; k < 6; k++) step();
      chk("credit_issue", 64'(issue_seen - base), 64'd17);
      chk("credit_outst2", 64'(outstanding), 64'd16);

      // Foreign cu_id returns nothing.
      resp(ID ^ 8'h01);
      step();
      chk("foreign_outst", 64'(outstanding), 64'd16);

      // Credit landing in the ISSUE cycle cancels the increment.
      resp(ID);
      chk("pre_issue_outst", 64'(outstanding), 64'd15);
      for (int k = 0; k < 10 && !cmd_out.valid; k++) step();
      chk("issue_seen_for_credit", 64'(cmd_out.valid), 64'd1);
      resp(ID);
      chk("issue_credit_outst", 64'(outstanding), 64'd15);
      for (int k = 0; k < 8; k++) step();
      chk("sb_issues19", 64'(issue_seen - base), 64'd19);
      chk("issued19", 64'(issued), 64'd19);
      chk("outst16", 64'(outstanding), 64'd16);

      // Disable while requesting; FIFO is retained and drains in order later.
      grant = 1'b0;
      push_cmd(32'h4000, 1'b1);
      push_cmd(32'h4010, 1'b1);
      resp(ID);
      for (int k = 0; k < 10 && !request; k++) step();
      chk("dis_req_up", 64'(request), 64'd1);
      enabled_in = 1'b0;
      step(); step();
      chk("dis_req_down", 64'(request), 64'd0);
      chk("dis_not_empty", 64'(status.empty), 64'd0);
      chk("dis_status_valid", 64'(status.valid), 64'd0);
      resp(ID); resp(ID); resp(ID);
      chk("dis_credits", 64'(outstanding), 64'd12);
      enabled_in = 1'b1;
      grant = 1'b1;
      for (int k = 0; k < 20; k++) step();
      chk("reen_issues", 64'(issue_seen - base), 64'd22);
      chk("reen_sb_empty", 64'(sb.size()), 64'd0);
      chk("reen_outst", 64'(outstanding), 64'd15);
      chk("reen_empty", 64'(status.empty), 64'd1);

      // Reset mid-operation with queued commands and credits in flight.
      grant = 1'b0;
      for (int k = 0; k < 10; k++) push_cmd(32'h5000 + 32'(k), 1'b1);
      rstn = 1'b0;
      #1;
      chk_reset_outputs("rst2");
      sb.delete();
      step(); step();
      rstn = 1'b1;
      grant = 1'b1;
      spur = 0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (request || cmd_out.valid) spur++;
      end
      chk("post_rst_spurious", 64'(spur), 64'd0);
      chk("post_rst_err", 64'(err), 64'd0);

      // Credit with nothing in flight.
      resp(ID);
      chk("underflow_outst", 64'(outstanding), 64'd0);
      chk("underflow_err", 64'(err), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
